// File: rtl/operand_scheduler_if.sv
// Byte-stream handshake plus committed-pair mux outputs for operand_scheduler.
interface operand_scheduler_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       hold;
  logic [7:0] x0;
  logic [7:0] x1;
  logic       select;
  logic       pair_valid;
  logic       commit;

  modport master (
    output din, din_valid, hold,
    input  din_ready, x0, x1, select, pair_valid, commit
  );

  modport slave (
    input  din, din_valid, hold,
    output din_ready, x0, x1, select, pair_valid, commit
  );
endinterface

// File: rtl/operand_scheduler.sv
// Pairs incoming bytes, commits them atomically to x0/x1 and alternates the
// mux select every DWELL cycles while a pair is committed.
module operand_scheduler #(
  parameter int unsigned DWELL = 4
) (
  input logic                 clk,
  input logic                 reset,
  operand_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, HALF, RUN, RUN_HALF} state_e;

  localparam logic [7:0] TERM = 8'(DWELL - 1);

  state_e     state_q, state_d;
  logic [7:0] s0_q, s0_d;
  logic [7:0] x0_q, x0_d;
  logic [7:0] x1_q, x1_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       pv_q, pv_d;
  logic       commit_q, commit_d;
  logic       xfer;

  assign bus.din_ready  = !bus.hold;
  assign bus.x0         = x0_q;
  assign bus.x1         = x1_q;
  assign bus.select     = sel_q;
  assign bus.pair_valid = pv_q;
  assign bus.commit     = commit_q;

  assign xfer = bus.din_valid && !bus.hold;

  always_comb begin
    state_d  = state_q;
    s0_d     = s0_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    pv_d     = pv_q;
    commit_d = 1'b0;

    if ((state_q == RUN || state_q == RUN_HALF) && !bus.hold) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
        sel_d = !sel_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    // Commit is evaluated after alternation so it overrides a same-cycle toggle.
    if (xfer) begin
      unique case (state_q)
        EMPTY: begin
          s0_d    = bus.din;
          state_d = HALF;
        end
        RUN: begin
          s0_d    = bus.din;
          state_d = RUN_HALF;
        end
        HALF, RUN_HALF: begin
          x0_d     = s0_q;
          x1_d     = bus.din;
          pv_d     = 1'b1;
          sel_d    = 1'b0;
          cnt_d    = '0;
          commit_d = 1'b1;
          state_d  = RUN;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      s0_q     <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      pv_q     <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s0_q     <= s0_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      pv_q     <= pv_d;
      commit_q <= commit_d;
    end
  end

endmodule

// File: tb/tb_operand_scheduler.sv
// Drives DWELL=4 and DWELL=1 schedulers with identical stimulus and checks
// both against a pair/phase model every cycle.
module tb_operand_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = !clk;

  operand_scheduler_if bus4 ();
  operand_scheduler_if bus1 ();

  operand_scheduler #(.DWELL(4)) u4 (.clk(clk), .reset(reset), .bus(bus4));
  operand_scheduler #(.DWELL(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    bit         have_a;
    logic [7:0] a;
    logic [7:0] x0;
    logic [7:0] x1;
    bit         pv;
    bit         commit;
    int         run;
  } model_t;

  model_t m4, m1;
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [7:0] din;
  logic       din_valid, hold;

  assign bus4.din = din;  assign bus4.din_valid = din_valid;  assign bus4.hold = hold;
  assign bus1.din = din;  assign bus1.din_valid = din_valid;  assign bus1.hold = hold;

  function automatic model_t step(model_t m, bit r, bit v, bit h, logic [7:0] d);
    model_t n = m;
    n.commit = 1'b0;
    if (r) begin
      n.have_a = 1'b0; n.a = '0; n.x0 = '0; n.x1 = '0;
      n.pv = 1'b0; n.run = 0;
      return n;
    end
    if (m.pv && !h) n.run = m.run + 1;
    if (v && !h) begin
      if (m.have_a) begin
        n.x0 = m.a; n.x1 = d; n.pv = 1'b1; n.run = 0;
        n.commit = 1'b1; n.have_a = 1'b0;
      end else begin
        n.a = d; n.have_a = 1'b1;
      end
    end
    return n;
  endfunction

  // Select is the phase parity of non-held cycles elapsed since the last commit.
  function automatic bit exp_sel(model_t m, int dwell);
    return m.pv ? bit'((m.run / dwell) % 2) : 1'b0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m4 = step(m4, reset, din_valid, hold, din);
    m1 = step(m1, reset, din_valid, hold, din);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d4_ready",  bus4.din_ready, !hold);
      chk("d4_x0",     bus4.x0, m4.x0);
      chk("d4_x1",     bus4.x1, m4.x1);
      chk("d4_pv",     bus4.pair_valid, m4.pv);
      chk("d4_commit", bus4.commit, m4.commit);
      chk("d4_select", bus4.select, exp_sel(m4, 4));
      chk("d1_ready",  bus1.din_ready, !hold);
      chk("d1_x0",     bus1.x0, m1.x0);
      chk("d1_x1",     bus1.x1, m1.x1);
      chk("d1_pv",     bus1.pair_valid, m1.pv);
      chk("d1_commit", bus1.commit, m1.commit);
      chk("d1_select", bus1.select, exp_sel(m1, 1));
    end
  end

  task automatic cyc(bit r, bit v, bit h, logic [7:0] d);
    reset = r; din_valid = v; hold = h; din = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    m4 = '{default: 0};
    m1 = '{default: 0};
    reset = 1'b1; din_valid = 1'b0; hold = 1'b0; din = '0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("lit_rst_x0", bus4.x0, 8'h00);
    chk("lit_rst_pv", bus4.pair_valid, 1'b0);
    chk("lit_rst_sel", bus4.select, 1'b0);

    // First pair
    cyc(1'b0, 1'b1, 1'b0, 8'h3C);
    chk("lit_half_pv", bus4.pair_valid, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'hA5);
    chk("lit_first_x0", bus4.x0, 8'h3C);
    chk("lit_first_x1", bus4.x1, 8'hA5);
    chk("lit_first_pv", bus4.pair_valid, 1'b1);
    chk("lit_first_commit", bus4.commit, 1'b1);
    chk("lit_first_sel", bus4.select, 1'b0);
    idle(1);
    chk("lit_commit_drop", bus4.commit, 1'b0);
    chk("lit_d1_sel1", bus1.select, 1'b1);
    idle(1);
    chk("lit_d1_sel2", bus1.select, 1'b0);
    idle(1);
    chk("lit_d4_sel3", bus4.select, 1'b0);
    idle(1);
    chk("lit_d4_sel4", bus4.select, 1'b1);
    idle(3);
    chk("lit_d4_sel7", bus4.select, 1'b1);
    idle(1);
    chk("lit_d4_sel8", bus4.select, 1'b0);

    // Atomic replace
    cyc(1'b0, 1'b1, 1'b0, 8'h11);
    idle(4);
    chk("lit_replace_x0_old", bus4.x0, 8'h3C);
    chk("lit_replace_x1_old", bus4.x1, 8'hA5);
    cyc(1'b0, 1'b1, 1'b0, 8'h22);
    chk("lit_replace_x0", bus4.x0, 8'h11);
    chk("lit_replace_x1", bus4.x1, 8'h22);
    chk("lit_replace_sel", bus4.select, 1'b0);

    // Hold mid-phase with a pending byte offered
    idle(2);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 8'h77);
    chk("lit_hold_x0", bus4.x0, 8'h11);
    chk("lit_hold_sel", bus4.select, 1'b0);
    idle(1);
    chk("lit_hold_resume3", bus4.select, 1'b0);
    idle(1);
    chk("lit_hold_resume4", bus4.select, 1'b1);

    // Collision: commit lands on the dwell-terminal edge
    cyc(1'b0, 1'b1, 1'b0, 8'h01);
    cyc(1'b0, 1'b1, 1'b0, 8'h02);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0, 8'h33);
    cyc(1'b0, 1'b1, 1'b0, 8'h44);
    chk("lit_coll_sel", bus4.select, 1'b0);
    chk("lit_coll_x1", bus4.x1, 8'h44);
    idle(3);
    chk("lit_coll_after", bus4.select, 1'b0);

    // Reset mid-pair
    cyc(1'b0, 1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("lit_mid_rst_pv", bus4.pair_valid, 1'b0);
    chk("lit_mid_rst_x0", bus4.x0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h01);
    cyc(1'b0, 1'b1, 1'b0, 8'h02);
    chk("lit_mid_rst_new_x0", bus4.x0, 8'h01);
    chk("lit_mid_rst_new_x1", bus4.x1, 8'h02);

    // Randomised traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 4) == 0), 8'($urandom));
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
